regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

- Shares the single write port of the 32×32-bit register file between two writeback requesters: port 0 is the ALU, port 1 is the load/store unit.
- Tracks a scoreboard of destination registers with writes still in flight, so the issue stage can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- `NREQ`, 2: number of writeback requesters; fixed at 2 in this revision.

Ports:
- `aclk` input 1: clock; all state updates on the rising edge.
- `areset` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: ALU writeback request.
- `req0_ready` output 1: ALU request accepted this cycle.
- `req0_rd` input 5: ALU destination register index.
- `req0_data` input 32: ALU write data.
- `req1_valid`, `req1_ready`, `req1_rd`, `req1_data`: same as port 0, for the load/store unit.
- `wr_en` output 1: register file write enable, registered.
- `wr_rd` output 5: register file write index, registered.
- `wr_data` output 32: register file write data, registered.
- `issue_valid` input 1: an instruction with destination `issue_rd` is issued this cycle.
- `issue_rd` input 5: destination index of the issuing instruction.
- `rs1` input 5, `rs2` input 5: source indices of the instruction being decoded.
- `rs1_busy`, `rs2_busy`, `rd_busy` output 1 each: the indexed register (`rs1`, `rs2`, `issue_rd`) has a pending write.
- `pending` output 32: raw scoreboard; bit 0 is always 0.

## Operation
- **Transfer rule:** a transfer on port k occurs when `reqk_valid && reqk_ready`.
- **Ready:** `reqk_ready` is the combinational grant.
  - It is never high unless `reqk_valid` is high.
  - At most one ready is high per cycle.
- **Single request:** granted immediately. The output stage accepts one write every cycle, so there is no backpressure.
- **Contention:** the arbitration policy decides; see Configuration.
- **Requester obligation:** a requester holds valid, rd and data stable until accepted. The arbiter never drops a valid request.
- **Staging register:** on a transfer, `wr_rd` ← `reqk_rd`, `wr_data` ← `reqk_data`, `wr_en` ← (`reqk_rd` != 0).
  - If no transfer occurs, `wr_en` ← 0 and `wr_rd`/`wr_data` hold their previous values.
- **rd = 0:** the request is accepted (ready asserted), and the write is silently discarded.
- **Scoreboard set:** on `issue_valid` with `issue_rd` != 0, `pending[issue_rd]` is set.
- **Scoreboard clear:** on any edge where `wr_en` = 1, `pending[wr_rd]` is cleared.
- **Same register set and cleared on one edge:** set wins; the register stays pending.
- **Busy outputs** are combinational from `pending`: `rs1_busy` = `pending[rs1]`, and likewise for `rs2_busy` and `rd_busy`. Index 0 always reads not busy.
- **Issue-stage obligation:** the issue stage must not issue while `rd_busy` is high. This is the WAW guard.
  - The arbiter does not check it; a violation leaves the bit set until the first write clears it.

## Timing
- **Reset values:** `wr_en`=0, `wr_rd`=0, `wr_data`=0, `pending`=0, round-robin pointer = "port 1 last granted" (so port 0 wins the first tie).
  - All busy and ready outputs are 0 unless driven by the combinational inputs.
- **Latency:**
  - Accept in cycle N.
  - `wr_en`/`wr_rd`/`wr_data` are valid in cycle N+1.
  - The register file captures the data on the edge ending N+1.
  - The scoreboard bit clears on that same edge; busy reads low from cycle N+2.
- **Throughput:** one write per cycle, sustained. Back-to-back grants to the same port are allowed when the other port is idle.
- **Reset mid-operation:** the staged write is discarded (`wr_en` forced to 0) and all pending bits are cleared.
  - Requesters must re-present after reset is released.
- **Combinational paths:** `reqk_ready` depends only on `req0_valid`, `req1_valid` and the pointer. The busy outputs depend only on `pending` and the indices.

## Configuration
- **Macro:** `REGFILE_WB_RR_EN`.
- **Defined:** round-robin arbitration.
  - On contention, grant the port that was not granted most recently.
  - The pointer updates only on a transfer.
- **Undefined:** fixed priority; port 1 (load/store) always wins contention.
  - The pointer register is not implemented.
  - Port 0 can starve only if port 1 is valid continuously.

## Test plan
- **Reset:** assert `areset` mid-stream with `wr_en`=1 → `wr_en`=0 and `pending`=0 immediately, asynchronously; `wr_rd`=0 and `wr_data`=0.
- **Single write:** `req0_valid`=1, rd=5, data=0xDEADBEEF at cycle N → `req0_ready`=1 at N; `wr_en`=1, `wr_rd`=5, `wr_data`=0xDEADBEEF at N+1; `wr_en`=0 at N+2.
- **Contention, round-robin:** both valid for 4 cycles (rd=3 on port 0, rd=7 on port 1) → grants 0,1,0,1 from reset.
  - Without the macro: grants 1,1,1,1 while port 1 stays valid.
- **rd = 0:** `req1_valid`=1, rd=0 → `req1_ready`=1; the next cycle `wr_en`=0; `pending` unchanged.
- **Scoreboard:** issue rd=9 at cycle 0 → `rs1_busy`=1 for `rs1`=9 from cycle 1; write rd=9 accepted at cycle 4 → busy low from cycle 6.
- **Set/clear collision:** `wr_en`=1 with `wr_rd`=12 on the same edge as an issue of rd=12 → `pending[12]` remains 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// ALU (port 0) and the load/store unit (port 1), and keeps a scoreboard of
// destination registers with writes in flight for RAW/WAW stalls in issue.
// Optional feature macro: REGFILE_WB_RR_EN
//   defined   -> round-robin arbitration on contention
//   undefined -> fixed priority, load/store (port 1) wins contention
module regfile_wb_arbiter #(
    parameter int NREQ = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        wr_en,
    output logic [4:0]  wr_rd,
    output logic [31:0] wr_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic [31:0] pending
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    logic [NREQ-1:0] gnt;
    wb_req_t         sel;
    logic [31:0]     pend_nxt;

`ifdef REGFILE_WB_RR_EN
    // 1 = port 1 was granted most recently; reset value lets port 0 win the first tie
    logic last1;

    // Round-robin grant: a lone requester wins, ties go to the port not granted last
    always_comb begin
        gnt    = '0;
        gnt[0] = req0_valid && (!req1_valid || last1);
        gnt[1] = req1_valid && (!req0_valid || !last1);
    end

    // Pointer moves only when a transfer actually happens
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)      last1 <= 1'b1;
        else if (gnt[0]) last1 <= 1'b0;
        else if (gnt[1]) last1 <= 1'b1;
    end
`else
    // Fixed priority grant: load/store always wins a tie
    always_comb begin
        gnt    = '0;
        gnt[1] = req1_valid;
        gnt[0] = req0_valid && !req1_valid;
    end
`endif

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Mux the winning request into the staging register input
    always_comb begin
        sel = gnt[1] ? wb_req_t'{rd: req1_rd, data: req1_data}
                     : wb_req_t'{rd: req0_rd, data: req0_data};
    end

    // Staging register: writes to x0 are accepted but never enabled
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else if (|gnt) begin
            wr_en   <= (sel.rd != 5'd0);
            wr_rd   <= sel.rd;
            wr_data <= sel.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Scoreboard next state: clear on retiring write, then set on issue so set wins
    always_comb begin
        pend_nxt = pending;
        if (wr_en)       pend_nxt[wr_rd]    = 1'b0;
        if (issue_valid) pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) pending <= '0;
        else        pending <= pend_nxt;
    end

    // Busy lookups; bit 0 is held at zero so x0 never reads busy
    assign rs1_busy = pending[rs1];
    assign rs2_busy = pending[rs2];
    assign rd_busy  = pending[issue_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change on the falling
// edge; combinational outputs are sampled 1ns later, registered outputs 1ns
// after the rising edge.
module tb_regfile_wb_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NREQ(2)) dut (
        .aclk(aclk), .areset(areset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy), .pending(pending)
    );

    always #5 aclk = ~aclk;

    task automatic idle_inputs();
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1; idle_inputs();
        @(negedge aclk);
        areset = 0;
    endtask

    task automatic test_reset();
        areset = 1; idle_inputs();
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); end
        @(negedge aclk); areset = 0;
        // mid-stream: stage a write and set a pending bit, then reset between edges
        @(negedge aclk);
        req0_valid = 1; req0_rd = 4; req0_data = 32'h1234_5678; issue_valid = 1; issue_rd = 6;
        @(posedge aclk); #1;
        checks++; if (wr_en !== 1'b1 || pending !== 32'h40) begin errors++; $display("FAIL pre_reset_state: got wr_en=%b pending=%h expected 1 00000040", wr_en, pending); end
        #2; areset = 1; idle_inputs(); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL async_reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_rd !== 5'd0 || wr_data !== 32'h0) begin errors++; $display("FAIL async_reset_wr: got rd=%0d data=%h expected 0 0", wr_rd, wr_data); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL async_reset_pending: got %h expected 0", pending); end
        @(negedge aclk); areset = 0;
    endtask

    task automatic test_single_write();
        @(negedge aclk);
        req0_valid = 1; req0_rd = 5; req0_data = 32'hDEAD_BEEF; #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready}); end
        @(posedge aclk); #1;
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_write: got en=%b rd=%0d data=%h expected 1 5 deadbeef", wr_en, wr_rd, wr_data); end
        @(negedge aclk); req0_valid = 0; #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL ready_without_valid: got %b expected 0", req0_ready); end
        @(posedge aclk); #1;
        checks++; if (wr_en !== 1'b0 || wr_rd !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_idle_hold: got en=%b rd=%0d data=%h expected 0 5 deadbeef", wr_en, wr_rd, wr_data); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic [4:0] exp_rd;
        do_reset();
        @(negedge aclk);
        req0_valid = 1; req0_rd = 3; req0_data = 32'h0000_0333;
        req1_valid = 1; req1_rd = 7; req1_data = 32'h0000_0777;
        for (int i = 0; i < 4; i++) begin
`ifdef REGFILE_WB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b10;
`endif
            exp_rd = exp_gnt[1] ? 5'd7 : 5'd3;
            #1;
            checks++; if ({req1_ready, req0_ready} !== exp_gnt) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, {req1_ready, req0_ready}, exp_gnt); end
            @(posedge aclk); #1;
            checks++; if (wr_en !== 1'b1 || wr_rd !== exp_rd) begin errors++; $display("FAIL contention_write[%0d]: got en=%b rd=%0d expected 1 %0d", i, wr_en, wr_rd, exp_rd); end
            @(negedge aclk);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_back_to_back();
        @(negedge aclk);
        req0_valid = 1; req0_rd = 1; req0_data = 32'hA1; #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", req0_ready); end
        @(negedge aclk);
        req0_rd = 2; req0_data = 32'hA2; #1;
        checks++; if (req0_ready !== 1'b1 || wr_rd !== 5'd1 || wr_data !== 32'hA1) begin errors++; $display("FAIL b2b_first: got rdy=%b rd=%0d data=%h expected 1 1 a1", req0_ready, wr_rd, wr_data); end
        @(negedge aclk);
        req0_valid = 0; #1;
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd2 || wr_data !== 32'hA2) begin errors++; $display("FAIL b2b_second: got en=%b rd=%0d data=%h expected 1 2 a2", wr_en, wr_rd, wr_data); end
    endtask

    task automatic test_rd_zero();
        @(negedge aclk);
        issue_valid = 1; issue_rd = 10;
        @(negedge aclk);
        issue_valid = 0; req1_valid = 1; req1_rd = 0; req1_data = 32'hFFFF_FFFF; #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b expected 1", req1_ready); end
        @(posedge aclk); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rd0_wr_en: got %b expected 0", wr_en); end
        checks++; if (pending !== 32'h0000_0400) begin errors++; $display("FAIL rd0_pending: got %h expected 00000400", pending); end
        @(negedge aclk);
        req1_valid = 0;
        do_reset();
    endtask

    task automatic test_scoreboard();
        // cycle 0: issue rd=9
        @(negedge aclk);
        issue_valid = 1; issue_rd = 9; rs1 = 9; rs2 = 0; #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_cycle0_busy: got %b expected 0", rs1_busy); end
        // cycles 1..3: busy
        for (int c = 1; c < 4; c++) begin
            @(negedge aclk);
            issue_valid = 0; #1;
            checks++; if (rs1_busy !== 1'b1 || rd_busy !== 1'b1 || rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_busy[%0d]: got rs1=%b rd=%b rs2=%b expected 1 1 0", c, rs1_busy, rd_busy, rs2_busy); end
        end
        // cycle 4: write accepted
        @(negedge aclk);
        req0_valid = 1; req0_rd = 9; req0_data = 32'h99; #1;
        checks++; if (req0_ready !== 1'b1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_cycle4: got rdy=%b busy=%b expected 1 1", req0_ready, rs1_busy); end
        // cycle 5: write staged, still busy
        @(negedge aclk);
        req0_valid = 0; #1;
        checks++; if (wr_en !== 1'b1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_cycle5: got en=%b busy=%b expected 1 1", wr_en, rs1_busy); end
        // cycle 6: cleared
        @(negedge aclk); #1;
        checks++; if (rs1_busy !== 1'b0 || pending !== 32'h0) begin errors++; $display("FAIL sb_cycle6: got busy=%b pending=%h expected 0 0", rs1_busy, pending); end
    endtask

    task automatic test_collision();
        @(negedge aclk);
        issue_valid = 1; issue_rd = 12;
        @(negedge aclk);
        issue_valid = 0; req1_valid = 1; req1_rd = 12; req1_data = 32'hC0C0;
        // wr_en=1 with wr_rd=12 in this cycle, issue 12 again on the same edge
        @(negedge aclk);
        req1_valid = 0; issue_valid = 1; issue_rd = 12; #1;
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd12) begin errors++; $display("FAIL coll_staged: got en=%b rd=%0d expected 1 12", wr_en, wr_rd); end
        @(negedge aclk);
        issue_valid = 0; rs2 = 12; #1;
        checks++; if (pending !== 32'h0000_1000 || rs2_busy !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got pending=%h busy=%b expected 00001000 1", pending, rs2_busy); end
        // a second write retires it
        req0_valid = 1; req0_rd = 12; req0_data = 32'hC1C1;
        @(negedge aclk);
        req0_valid = 0;
        @(negedge aclk); #1;
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL coll_final_clear: got %h expected 0", pending); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_rd_zero();
        test_scoreboard();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
